// File: rtl/packet_pkg.sv
// rtl/packet_pkg.sv - shared packet word type for the assembly, buffering and processing stages
package packet_pkg;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] tag;
  } packet_t;

  localparam int PKT_W = $bits(packet_t);

endpackage

// File: rtl/packet_fifo_mem.sv
// rtl/packet_fifo_mem.sv - DEPTH x packet word register array, one write port, one async read port
module packet_fifo_mem
  import packet_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PKT_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PKT_W-1:0] rdata
);

  // Storage is deliberately left unreset; the pointers alone define validity.
  logic [PKT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/packet_fifo.sv
// rtl/packet_fifo.sv - show-ahead packet FIFO with flush; PACKET_FIFO_LEVEL_EN adds level/almost_full
module packet_fifo
  import packet_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt
`ifdef PACKET_FIFO_LEVEL_EN
  ,
  output logic [AW:0]      level,
  output logic             almost_full
`endif
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  // Flags are gated by rst so nothing leaks out during the reset cycle itself.
  assign in_ready  = !full && !rst;
  assign out_valid = !empty && !rst;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  packet_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push && !flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (in_pkt),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (out_pkt)
  );

`ifdef PACKET_FIFO_LEVEL_EN
  localparam logic [AW:0] AF_LEVEL = (AW + 1)'(DEPTH - 1);

  logic [AW:0] count;

  // Tracks wr_ptr - rd_ptr without needing the subtractor on the output path.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + PTR_ONE;
        2'b01:   count <= count - PTR_ONE;
        default: count <= count;
      endcase
    end
  end

  assign level       = rst ? '0 : count;
  assign almost_full = !rst && (count >= AF_LEVEL);
`endif

endmodule

// File: tb/tb_packet_fifo.sv
// tb/tb_packet_fifo.sv - directed self-checking bench for packet_fifo (DEPTH=4)
module tb_packet_fifo;
  import packet_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [PKT_W-1:0] in_pkt;
  logic             out_valid;
  logic             out_ready;
  logic [PKT_W-1:0] out_pkt;
`ifdef PACKET_FIFO_LEVEL_EN
  logic [2:0]       level;
  logic             almost_full;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  packet_fifo #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pkt      (in_pkt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pkt     (out_pkt)
`ifdef PACKET_FIFO_LEVEL_EN
    ,
    .level       (level),
    .almost_full (almost_full)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_level(input string tag, input int exp);
`ifdef PACKET_FIFO_LEVEL_EN
    check(tag, 32'(level), 32'(exp));
`endif
  endtask

  task automatic push_word(input logic [PKT_W-1:0] pkt);
    in_valid = 1'b1;
    in_pkt   = pkt;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pkt = '0;
    #1;
    check("rst_in_ready_0", 32'(in_ready), 0);
    check("rst_out_valid_0", 32'(out_valid), 0);
    tick();
    tick();
    check("rst_in_ready_2", 32'(in_ready), 0);
    check("rst_out_valid_2", 32'(out_valid), 0);
    check_level("rst_level", 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);
    check("rel_out_valid", 32'(out_valid), 0);
    check_level("rel_level", 0);

    // single word, first-word latency of one edge
    push_word({8'hA5, 4'h3});
    check("one_out_valid", 32'(out_valid), 1);
    check("one_out_pkt", 32'(out_pkt), 32'h000A53);
    check_level("one_level", 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("one_pop_empty", 32'(out_valid), 0);

    // fill to full, 5th word held until a pop frees a slot
    for (int i = 1; i <= 4; i++) begin
      check("fill_in_ready", 32'(in_ready), 1);
      push_word({8'(i), 4'h0});
    end
    in_valid = 1'b1;
    in_pkt   = {8'h05, 4'h0};
    #1;
    check("full_in_ready", 32'(in_ready), 0);
    check_level("full_level", 4);
`ifdef PACKET_FIFO_LEVEL_EN
    check("full_almost_full", 32'(almost_full), 1);
`endif
    tick();
    check("full_hold_head", 32'(out_pkt), 32'h010);
    check("full_hold_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("after_pop_ready", 32'(in_ready), 1);
    check("after_pop_head", 32'(out_pkt), 32'h020);
    check_level("after_pop_level", 3);
    tick();
    in_valid = 1'b0;
    #1;
    check("refull_ready", 32'(in_ready), 0);
    check_level("refull_level", 4);
    out_ready = 1'b1;
    #1;
    for (int k = 2; k <= 5; k++) begin
      check("drain_valid", 32'(out_valid), 1);
      check("drain_pkt", 32'(out_pkt), 32'({8'(k), 4'h0}));
      tick();
    end
    out_ready = 1'b0;
    #1;
    check("drain_empty", 32'(out_valid), 0);

    // streaming push+pop across several pointer wraps
    in_valid  = 1'b1;
    in_pkt    = {8'h00, 4'h5};
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("stream_valid", 32'(out_valid), 1);
      check("stream_pkt", 32'(out_pkt), 32'({8'(i), 4'h5}));
      check_level("stream_level", 1);
      if (i < 15) in_pkt = {8'(i + 1), 4'h5};
      else        in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    #1;
    check("stream_empty", 32'(out_valid), 0);

    // flush with a concurrent push discards everything
    push_word({8'h11, 4'h1});
    push_word({8'h12, 4'h2});
    push_word({8'h13, 4'h3});
    check_level("preflush_level", 3);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_pkt   = {8'h99, 4'h9};
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", 32'(out_valid), 0);
    check("flush_in_ready", 32'(in_ready), 1);
    check_level("flush_level", 0);
    push_word({8'h21, 4'h1});
    check("postflush_pkt", 32'(out_pkt), 32'h0211);
    check_level("postflush_level", 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("postflush_empty", 32'(out_valid), 0);

    // reset mid-stream loses buffered words
    push_word({8'h31, 4'h1});
    push_word({8'h32, 4'h2});
    out_ready = 1'b1;
    rst       = 1'b1;
    #1;
    check("midrst_valid_now", 32'(out_valid), 0);
    check("midrst_ready_now", 32'(in_ready), 0);
    tick();
    check("midrst_valid_1", 32'(out_valid), 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_valid_rel", 32'(out_valid), 0);
    check_level("midrst_level", 0);
    out_ready = 1'b0;
    push_word({8'h41, 4'h4});
    check("midrst_first_valid", 32'(out_valid), 1);
    check("midrst_first_pkt", 32'(out_pkt), 32'h0414);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    check("midrst_final_empty", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
